uart_frame_tx: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 29 ++
 rtl/uart_byte_tx.sv | 142 ++++++++++++++
 rtl/uart_frame_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_frame_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared types for the UART frame transmitter:
//   frame_state_e     - frame-level FSM states (FILL, SYNC, DATA)
//   bit_state_e       - byte serialiser states (B_IDLE .. B_STOP)
//   bytes_per_sample  - bytes needed to carry one sample of a given width
// Optional feature macro used by the including files: UART_PARITY_EN.
// -----------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [1:0] {
    FILL,
    SYNC,
    DATA
  } frame_state_e;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_PAR,
    B_STOP
  } bit_state_e;

  function automatic int bytes_per_sample(input int bit_width);
    return (bit_width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Serialises one byte per request: start(0), 8 data bits LSB first,
// optional even parity, stop(1). Each bit lasts CLKS_PER_BIT cycles.
// Macro: UART_PARITY_EN - when defined an even parity bit is sent between the
// last data bit and the stop bit (11 bit times per byte, otherwise 8N1).
// Ports:
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset (line forced high)
//   tx_start   load tx_byte; honoured in B_IDLE or in the last stop cycle
//   tx_byte    byte to send
//   tx_o       serial line, idles high
//   tx_busy    a byte is on the line
//   byte_done  high during the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_byte_tx
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_o,
  output logic       tx_busy,
  output logic       byte_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  bit_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [7:0]       r_shift, w_shift_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next;
  logic             r_tx, w_tx_next;
`ifdef UART_PARITY_EN
  logic             r_par, w_par_next;
`endif

  logic w_bit_end;
  logic w_accept;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign byte_done = (r_state == B_STOP) && w_bit_end;
  // Accepting in the last stop cycle lets the next start bit follow with no gap.
  assign w_accept  = tx_start && ((r_state == B_IDLE) || byte_done);
  assign tx_o      = r_tx;
  assign tx_busy   = (r_state != B_IDLE);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = w_bit_end ? '0 : r_cnt + 1'b1;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = r_tx;
`ifdef UART_PARITY_EN
    w_par_next     = r_par;
`endif
    case (r_state)
      B_IDLE: begin
        w_cnt_next = '0;
        w_tx_next  = 1'b1;
      end
      B_START: begin
        if (w_bit_end) begin
          w_state_next   = B_DATA;
          w_bit_idx_next = 3'd0;
          w_tx_next      = r_shift[0];
        end
      end
      B_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            w_state_next = B_PAR;
            w_tx_next    = r_par;
`else
            w_state_next = B_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = r_shift >> 1;
            w_tx_next      = r_shift[1];
          end
        end
      end
      B_PAR: begin
        if (w_bit_end) begin
          w_state_next = B_STOP;
          w_tx_next    = 1'b1;
        end
      end
      B_STOP: begin
        if (w_bit_end) begin
          w_state_next = B_IDLE;
          w_tx_next    = 1'b1;
        end
      end
      default: begin
        w_state_next = B_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase

    if (w_accept) begin
      w_state_next   = B_START;
      w_cnt_next     = '0;
      w_shift_next   = tx_byte;
      w_bit_idx_next = 3'd0;
      w_tx_next      = 1'b0;
`ifdef UART_PARITY_EN
      w_par_next     = ^tx_byte;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= B_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
`ifdef UART_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
`ifdef UART_PARITY_EN
      r_par     <= w_par_next;
`endif
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
// Buffers N signed samples of BIT_WIDTH bits, then sends one frame: SYNC_BYTE
// followed by every sample little-endian in ceil(BIT_WIDTH/8) bytes (top byte
// sign-extended). Bytes are back-to-back on the line.
// Macro: UART_PARITY_EN - adds an even parity bit to every byte (see
// uart_byte_tx); default build is 8N1.
// Ports:
//   CLK         system clock, rising edge
//   RST_N       asynchronous active-low reset; discards any partial frame
//   s_data      sample to buffer
//   s_valid     s_data valid (held by the producer while s_ready=0)
//   s_ready     buffer accepts a sample this cycle (state FILL)
//   tx_o        UART serial line, idles high
//   busy        frame transmission in progress
//   frame_done  one-cycle pulse after the last stop bit of the frame
// -----------------------------------------------------------------------------
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          BAUD      = 115200,
  parameter int          BIT_WIDTH = 24,
  parameter int          N         = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [BIT_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx_o,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int B            = bytes_per_sample(BIT_WIDTH);
  localparam int PTR_W        = $clog2(N);

  frame_state_e r_state, w_state_next;

  logic [BIT_WIDTH-1:0] r_buf [N];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_samp_idx;
  logic [1:0]           r_byte_idx;
  logic                 r_last_loaded;
  logic                 r_frame_done;

  logic                 w_write;
  logic                 w_load;
  logic                 w_frame_end;
  logic                 w_tx_start;
  logic [7:0]           w_tx_byte;
  logic                 w_byte_done;
  logic                 w_byte_busy;
  logic [BIT_WIDTH-1:0] w_sample;
  logic [31:0]          w_ext;
  logic [7:0]           w_data_byte;

  // Sign-extend to 32 bits once; bytes above B are never selected.
  assign w_sample    = r_buf[r_samp_idx];
  assign w_ext       = 32'($signed(w_sample));
  assign w_data_byte = w_ext[{r_byte_idx, 3'b000} +: 8];

  assign s_ready    = (r_state == FILL);
  assign busy       = (r_state != FILL) || w_byte_busy;
  assign frame_done = r_frame_done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= FILL;
    else        r_state <= w_state_next;
  end

  // The sync byte is handed to the serialiser in the same cycle the last
  // sample is written, so its start bit begins right after that edge.
  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_load       = 1'b0;
    w_frame_end  = 1'b0;
    w_tx_start   = 1'b0;
    w_tx_byte    = w_data_byte;
    case (r_state)
      FILL: begin
        w_tx_byte = SYNC_BYTE;
        if (s_valid) begin
          w_write = 1'b1;
          if (r_wr_ptr == PTR_W'(N - 1)) begin
            w_tx_start   = 1'b1;
            w_state_next = SYNC;
          end
        end
      end
      SYNC: begin
        if (w_byte_done) begin
          w_tx_start   = 1'b1;
          w_load       = 1'b1;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_byte_done) begin
          if (r_last_loaded) begin
            w_frame_end  = 1'b1;
            w_state_next = FILL;
          end else begin
            w_tx_start = 1'b1;
            w_load     = 1'b1;
          end
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // Sample storage; no reset needed, every slot is rewritten before use.
  always_ff @(posedge CLK) begin
    if (w_write) r_buf[r_wr_ptr] <= s_data;
  end

  // r_samp_idx/r_byte_idx always name the next byte to hand to the serialiser.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr      <= '0;
      r_samp_idx    <= '0;
      r_byte_idx    <= '0;
      r_last_loaded <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      // N is a power of two, so the pointer wraps to 0 after the Nth write.
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_frame_end) begin
        r_samp_idx    <= '0;
        r_byte_idx    <= '0;
        r_last_loaded <= 1'b0;
      end else if (w_load) begin
        if (r_byte_idx == 2'(B - 1)) begin
          r_byte_idx <= '0;
          if (r_samp_idx == PTR_W'(N - 1)) r_last_loaded <= 1'b1;
          else                             r_samp_idx    <= r_samp_idx + 1'b1;
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .tx_start (w_tx_start),
    .tx_byte  (w_tx_byte),
    .tx_o     (tx_o),
    .tx_busy  (w_byte_busy),
    .byte_done(w_byte_done)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_tx
// Directed bench for uart_frame_tx at 10 clocks per bit. A 24-bit / N=4
// instance covers reset, framing, backpressure and mid-frame reset; a
// 12-bit / N=2 instance covers sign extension. Honours UART_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_frame_tx;

`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, tx_o, busy, frame_done;
  logic [11:0] s12_data = '0;
  logic        s12_valid = 1'b0;
  logic        s12_ready, tx12, busy12, done12;

  logic sel = 1'b0;
  logic m_tx, m_busy, m_ready, m_done;
  assign m_tx    = sel ? tx12      : tx_o;
  assign m_busy  = sel ? busy12    : busy;
  assign m_ready = sel ? s12_ready : s_ready;
  assign m_done  = sel ? done12    : frame_done;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .CLK_HZ(50_000_000), .BAUD(5_000_000), .BIT_WIDTH(24), .N(4), .SYNC_BYTE(8'hA5)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tx_o(tx_o), .busy(busy), .frame_done(frame_done)
  );

  uart_frame_tx #(
    .CLK_HZ(50_000_000), .BAUD(5_000_000), .BIT_WIDTH(12), .N(2), .SYNC_BYTE(8'hA5)
  ) dut12 (
    .CLK(clk), .RST_N(rst_n), .s_data(s12_data), .s_valid(s12_valid),
    .s_ready(s12_ready), .tx_o(tx12), .busy(busy12), .frame_done(done12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a negedge; the sample is written at the following posedge.
  task automatic push(input logic [23:0] v);
    s_data  = v;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Entered at the negedge of the first start-bit cycle; returns at the
  // mid-point of the stop bit. All sampling is at bit centres.
  task automatic get_byte(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    repeat (CPB / 2) @(negedge clk);
    chk({tag, "_start"}, m_tx, 1'b0);
    chk({tag, "_busy"}, m_busy, 1'b1);
    chk({tag, "_ready"}, m_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = m_tx;
    end
    chk({tag, "_data"}, d, exp);
`ifdef UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    chk({tag, "_parity"}, m_tx, ^exp);
`endif
    repeat (CPB) @(negedge clk);
    chk({tag, "_stop"}, m_tx, 1'b1);
    $display("  %s: byte expected %h observed %h", tag, exp, d);
  endtask

  // Entered at the negedge right after the edge that wrote the last sample;
  // returns at the negedge of the frame_done cycle.
  task automatic check_frame(input string name, input logic [7:0] exp [13], input int n);
    chk({name, "_first_start"}, m_tx, 1'b0);
    for (int m = 0; m < n; m++) begin
      get_byte($sformatf("%s_b%0d", name, m), exp[m]);
      if (m < n - 1) repeat (CPB / 2) @(negedge clk);
    end
    repeat (CPB / 2 - 1) @(negedge clk);
    chk({name, "_last_stop_done"}, m_done, 1'b0);
    chk({name, "_last_stop_busy"}, m_busy, 1'b1);
    @(negedge clk);
    chk({name, "_done_pulse"}, m_done, 1'b1);
    chk({name, "_done_ready"}, m_ready, 1'b1);
    chk({name, "_done_busy"}, m_busy, 1'b0);
    $display("%s: %0d bytes, frame_done after %0d cycles", name, n, n * FB * CPB);
  endtask

  initial begin
    logic idle_ok;

    // Reset state
    @(negedge clk);
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) idle_ok = 1'b0;
    end
    chk("idle_100", idle_ok, 1'b1);
    $display("reset/idle: 100 cycles observed");

    // Frame 1: the reference frame
    push(24'h000001);
    push(24'h123456);
    push(24'h800000);
    chk("f1_pre_tx", tx_o, 1'b1);
    push(24'hFFFFFF);
    check_frame("f1", '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h56, 8'h34, 8'h12,
                        8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'hFF}, 13);
    @(negedge clk);
    chk("f1_done_width", frame_done, 1'b0);

    // Frame 2: producer holds 0x0000AA valid for the whole frame
    push(24'h7FFFFF);
    push(24'h000100);
    push(24'hABCDEF);
    push(24'h000002);
    s_data  = 24'h0000AA;
    s_valid = 1'b1;
    check_frame("f2", '{8'hA5, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h01, 8'h00,
                        8'hEF, 8'hCD, 8'hAB, 8'h02, 8'h00, 8'h00}, 13);
    // The held sample is taken at the end of the frame_done cycle.
    @(negedge clk);
    s_valid = 1'b0;
    chk("f2_done_width", frame_done, 1'b0);
    chk("f2_still_fill", s_ready, 1'b1);

    // Frame 3: 0xAA accepted back-to-back is sample 0
    push(24'h000010);
    push(24'h000020);
    chk("f3_pre_tx", tx_o, 1'b1);
    push(24'h000030);
    check_frame("f3", '{8'hA5, 8'hAA, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
                        8'h20, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00}, 13);
    @(negedge clk);

    // Frame 4: reset during byte 3 (a 0x00 byte, so the line is low)
    push(24'h000001);
    push(24'h000002);
    push(24'h000003);
    push(24'h000004);
    repeat (3 * FB * CPB + CPB / 2) @(negedge clk);
    chk("mrst_line_low", tx_o, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_tx_high", tx_o, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ready", s_ready, 1'b1);
    $display("mid-frame reset: tx_o=%b busy=%b", tx_o, busy);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 5: fresh frame after reset
    push(24'h000005);
    push(24'h000006);
    push(24'h000007);
    push(24'h000008);
    check_frame("f5", '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00,
                        8'h07, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00}, 13);
    @(negedge clk);

    // 12-bit instance: sign extension of the top byte
    sel       = 1'b1;
    s12_data  = 12'h800;
    s12_valid = 1'b1;
    @(negedge clk);
    chk("w12_pre_tx", tx12, 1'b1);
    s12_data = 12'h7FF;
    @(negedge clk);
    s12_valid = 1'b0;
    check_frame("w12", '{8'hA5, 8'h00, 8'hF8, 8'hFF, 8'h07, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
